wash_panel_ctrl: RTL and testbench

Front-panel and coin-acceptor controller that drives the washing machine controller's command inputs and consumes its completion flag. It debounces the raw coin sensor and panel buttons, accumulates credit, prices the selected programme (single or double wash), and issues the one-cycle `coin_in` start pulse once credit covers the price. While a cycle runs it holds `double_wash`, toggles `timer_pause` from the pause button, and on the rising edge of `wash_done` runs an end-of-cycle buzzer phase before accepting the next start.

---
 rtl/wash_panel_ctrl.sv | 148 ++++++++++++++
 tb/tb_wash_panel_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_panel_ctrl.sv
// wash_panel_ctrl: coin/panel front end for the wash controller; pause path built only when WASH_PANEL_PAUSE_EN is defined
module wash_panel_ctrl #(
   parameter int PRICE_SINGLE    = 2,
   parameter int PRICE_DOUBLE    = 3,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int DONE_CYCLES     = 8,
   parameter int CREDIT_W        = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_sense,
   input  logic                double_btn,
   input  logic                pause_btn,
   input  logic                wash_done,
   output logic                coin_in,
   output logic                double_wash,
   output logic                timer_pause,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                busy,
   output logic                buzzer
);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam int DNW = $clog2(DONE_CYCLES) + 1;
`ifdef WASH_PANEL_PAUSE_EN
   localparam int N = 3;
`else
   localparam int N = 2;
`endif

   typedef enum logic [2:0] {READY, CREDIT, START, RUNNING, DONE} state_t;

   logic [N-1:0]        raw, sync1, sync2, deb, deb_q, ev;
   logic [DBW-1:0]      cnt [N];
   state_t              state, state_nx;
   logic [CREDIT_W-1:0] credit_nx, price;
   logic [DNW-1:0]      dcnt, dcnt_nx;
   logic                sel, sel_nx, tp, tp_nx, rej_nx, wd_q;
   logic                coin_ev, dbl_ev, pause_ev, done_rise;

`ifdef WASH_PANEL_PAUSE_EN
   assign raw      = {pause_btn, double_btn, coin_sense};
   assign pause_ev = ev[2];
`else
   logic unused_pause;
   assign unused_pause = pause_btn;
   assign raw          = {double_btn, coin_sense};
   assign pause_ev     = 1'b0;
`endif

   assign ev          = deb & ~deb_q;
   assign coin_ev     = ev[0];
   assign dbl_ev      = ev[1];
   assign done_rise   = wash_done & ~wd_q;
   assign price       = sel ? CREDIT_W'(PRICE_DOUBLE) : CREDIT_W'(PRICE_SINGLE);
   assign double_wash = sel;
   assign timer_pause = tp;

   // synchronize raw inputs and accept a level only after it has been stable long enough
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_q <= '0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < N; i++) begin
            if (sync2[i] == deb[i]) cnt[i] <= '0;
            else if (cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else cnt[i] <= cnt[i] + DBW'(1);
         end
      end
   end

   // state, credit, selection and pause registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= READY;
         credit      <= '0;
         sel         <= 1'b0;
         tp          <= 1'b0;
         coin_reject <= 1'b0;
         dcnt        <= '0;
         wd_q        <= 1'b0;
      end else begin
         state       <= state_nx;
         credit      <= credit_nx;
         sel         <= sel_nx;
         tp          <= tp_nx;
         coin_reject <= rej_nx;
         dcnt        <= dcnt_nx;
         wd_q        <= wash_done;
      end
   end

   // next state and outputs; selection is frozen once a purchase commits so the price cannot change under it
   always_comb begin
      state_nx  = state;
      credit_nx = (coin_ev && credit != '1) ? credit + CREDIT_W'(1) : credit;
      rej_nx    = coin_ev && credit == '1;
      sel_nx    = sel;
      tp_nx     = tp;
      dcnt_nx   = '0;
      coin_in   = 1'b0;
      busy      = 1'b0;
      buzzer    = 1'b0;
      case (state)
         READY: begin
            sel_nx = sel ^ dbl_ev;
            if (coin_ev) state_nx = CREDIT;
         end
         CREDIT: begin
            if (credit >= price) state_nx = START;
            else sel_nx = sel ^ dbl_ev;
         end
         START: begin
            coin_in   = 1'b1;
            busy      = 1'b1;
            credit_nx = credit - price + CREDIT_W'(coin_ev);
            rej_nx    = 1'b0;
            state_nx  = RUNNING;
         end
         RUNNING: begin
            busy = 1'b1;
            if (done_rise) begin
               tp_nx    = 1'b0;
               state_nx = DONE;
            end else tp_nx = tp ^ pause_ev;
         end
         DONE: begin
            buzzer  = 1'b1;
            dcnt_nx = dcnt + DNW'(1);
            if (dcnt == DNW'(DONE_CYCLES - 1)) begin
               dcnt_nx  = '0;
               state_nx = (credit_nx != '0) ? CREDIT : READY;
               sel_nx   = sel & (credit_nx != '0);
            end
         end
         default: state_nx = READY;
      endcase
   end
endmodule

// File: tb/tb_wash_panel_ctrl.sv
// tb_wash_panel_ctrl: directed and random panel/coin scenarios checked against a transaction-level credit model
module tb_wash_panel_ctrl;
   localparam int D  = 4;
   localparam int DC = 8;
   localparam int CW = 2;
   localparam int PS = 2;
   localparam int PD = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          coin_sense = 1'b0, double_btn = 1'b0, pause_btn = 1'b0, wash_done = 1'b0;
   logic          coin_in, double_wash, timer_pause, coin_reject, busy, buzzer;
   logic [CW-1:0] credit;

   int checks = 0, passed = 0;
   int n_ci = 0, n_ci_cyc = 0, n_rej = 0, n_buz = 0;
   logic ci_q = 1'b0;
   int m_credit = 0, m_sel = 0, m_run = 0, m_tp = 0, m_starts = 0, m_rej = 0, m_dones = 0;

   wash_panel_ctrl #(
      .PRICE_SINGLE(PS), .PRICE_DOUBLE(PD), .DEBOUNCE_CYCLES(D), .DONE_CYCLES(DC), .CREDIT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .coin_sense(coin_sense), .double_btn(double_btn),
      .pause_btn(pause_btn), .wash_done(wash_done), .coin_in(coin_in), .double_wash(double_wash),
      .timer_pause(timer_pause), .credit(credit), .coin_reject(coin_reject), .busy(busy), .buzzer(buzzer)
   );

   always #5 clk = ~clk;

   // count output pulses and buzzer cycles on the falling edge
   always @(negedge clk) begin
      if (coin_in) n_ci_cyc++;
      if (coin_in && !ci_q) n_ci++;
      if (coin_reject) n_rej++;
      if (buzzer) n_buz++;
      ci_q <= coin_in;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic verify();
      chk("credit", credit, m_credit);
      chk("double_wash", double_wash, m_sel);
      chk("busy", busy, m_run);
      chk("timer_pause", timer_pause, m_tp);
      chk("coin_in_pulses", n_ci, m_starts);
      chk("coin_in_cycles", n_ci_cyc, m_starts);
      chk("coin_reject_pulses", n_rej, m_rej);
      chk("buzzer_cycles", n_buz, DC * m_dones);
      chk("buzzer_idle", buzzer, 0);
   endtask

   function automatic void settle();
      int price = m_sel ? PD : PS;
      if (!m_run && m_credit >= price) begin
         m_credit -= price;
         m_starts++;
         m_run = 1;
      end
   endfunction

   task automatic pulse(input int which, input int len);
      case (which)
         0: coin_sense = 1'b1;
         1: double_btn = 1'b1;
         default: pause_btn = 1'b1;
      endcase
      cyc(len);
      coin_sense = 1'b0;
      double_btn = 1'b0;
      pause_btn  = 1'b0;
      cyc(20);
   endtask

   task automatic coin_step();
      pulse(0, $urandom_range(6, 12));
      if (m_credit == CMAX) m_rej++;
      else m_credit++;
      settle();
      verify();
   endtask

   task automatic glitch_step();
      pulse(0, $urandom_range(1, 3));
      verify();
   endtask

   task automatic dbl_step();
      pulse(1, 6);
      if (!m_run) m_sel ^= 1;
      settle();
      verify();
   endtask

   task automatic pause_step();
      pulse(2, 6);
`ifdef WASH_PANEL_PAUSE_EN
      if (m_run) m_tp ^= 1;
`endif
      verify();
   endtask

   task automatic done_step(input bit hold);
      if (wash_done) begin
         wash_done = 1'b0;
         cyc(3);
      end
      wash_done = 1'b1;
      if (!hold) begin
         cyc(2);
         wash_done = 1'b0;
      end
      cyc(22);
      if (m_run) begin
         m_run = 0;
         m_tp  = 0;
         m_dones++;
         if (m_credit == 0) m_sel = 0;
         settle();
      end
      verify();
   endtask

   initial begin
      cyc(3);
      chk("rst_coin_in", coin_in, 0);
      chk("rst_credit", credit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_buzzer", buzzer, 0);
      chk("rst_double_wash", double_wash, 0);
      chk("rst_timer_pause", timer_pause, 0);
      chk("rst_coin_reject", coin_reject, 0);
      rst_n = 1'b1;
      cyc(3);

      // single wash with exact latencies
      coin_sense = 1'b1;
      cyc(D + 2);
      chk("coin1_before", credit, 0);
      cyc(1);
      chk("coin1_after", credit, 1);
      cyc(4);
      coin_sense = 1'b0;
      cyc(20);
      m_credit = 1;
      verify();
      coin_sense = 1'b1;
      cyc(D + 3);
      chk("coin2_credit", credit, 2);
      chk("coin2_no_start", coin_in, 0);
      cyc(1);
      chk("start_pulse", coin_in, 1);
      chk("start_busy", busy, 1);
      cyc(1);
      chk("start_once", coin_in, 0);
      chk("start_credit", credit, 0);
      chk("start_single", double_wash, 0);
      cyc(1);
      coin_sense = 1'b0;
      cyc(20);
      m_credit = 0;
      m_starts = 1;
      m_run = 1;
      verify();
      wash_done = 1'b1;
      cyc(1);
      chk("buzzer_first", buzzer, 1);
      cyc(DC - 1);
      chk("buzzer_last", buzzer, 1);
      cyc(1);
      chk("buzzer_off", buzzer, 0);
      chk("ready_busy", busy, 0);
      wash_done = 1'b0;
      cyc(10);
      m_run = 0;
      m_dones = 1;
      verify();

      // double wash, bounce, pause, carry and saturation, stale done
      coin_step();
      dbl_step();
      coin_step();
      glitch_step();
      coin_step();
      pause_step();
      pause_step();
      repeat (4) coin_step();
      pause_step();
      done_step(1'b1);
      coin_step();
      done_step(1'b0);

      for (int s = 0; s < 70; s++) begin
         case ($urandom_range(0, 6))
            0, 1: coin_step();
            2: glitch_step();
            3: dbl_step();
            4: pause_step();
            5: done_step(1'($urandom_range(0, 1)));
            default: done_step(1'b0);
         endcase
      end

      // asynchronous reset while running
      for (int k = 0; k < 4 && !m_run; k++) coin_step();
      pause_step();
      rst_n = 1'b0;
      #1;
      chk("arst_coin_in", coin_in, 0);
      chk("arst_credit", credit, 0);
      chk("arst_busy", busy, 0);
      chk("arst_buzzer", buzzer, 0);
      chk("arst_double_wash", double_wash, 0);
      chk("arst_timer_pause", timer_pause, 0);
      chk("arst_coin_reject", coin_reject, 0);
      wash_done = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      m_credit = 0;
      m_sel = 0;
      m_run = 0;
      m_tp = 0;
      cyc(3);
      verify();
      coin_step();
      pause_step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
